// File: rtl/nand_chk_pkg.sv
// Shared types and constants for the quad NAND stimulus/checker.
// The VEC_* constants describe the default W=4 build; the top derives its own widths from W.
package nand_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int GATE_W = 4;
    localparam int VEC_W  = 2 * GATE_W;
    localparam logic [VEC_W-1:0] VEC_LAST = '1;

endpackage

// File: rtl/nand_chk_settle_timer.sv
// Down-counter that holds each vector for SETTLE cycles before the compare.
// zero is high once the preload has counted out; it stays high until the next load.
module nand_chk_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    logic [3:0] scnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= 4'd0;
        end else if (load) begin
            scnt <= 4'(SETTLE - 1);
        end else if (scnt != 4'd0) begin
            scnt <= scnt - 4'd1;
        end
    end

    assign zero = (scnt == 4'd0);

endmodule

// File: rtl/nand_quad_vec_checker.sv
// Exhaustive sweep of all (A,B) pairs into a W-bit NAND gate, checking Y against ~(A&B).
// The vector counter itself is the registered gate drive: a_out/b_out are its two halves.
module nand_quad_vec_checker
    import nand_chk_pkg::*;
#(
    parameter int W      = 4,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    input  logic [W-1:0]   y_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_cnt,
    output logic           fail_valid,
    output logic [2*W-1:0] fail_vec
);

    localparam int VW = 2 * W;
    localparam logic [VW-1:0] VLAST = '1;

    state_t          state, state_nxt;
    logic [VW-1:0]   vec;
    logic            accept;
    logic            load;
    logic            zero;
    logic            mismatch;
    logic            last_vec;

    nand_chk_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .zero (zero)
    );

    assign a_out    = vec[W-1:0];
    assign b_out    = vec[VW-1:W];
    assign mismatch = |(y_in ^ ~(a_out & b_out));
    assign last_vec = (vec == VLAST);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (zero) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (last_vec) begin
                    state_nxt = ST_DONE;
                end else begin
                    load      = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                vec        <= '0;
                err_cnt    <= '0;
                fail_valid <= 1'b0;
            end else if (state == ST_CHECK) begin
                // err_cnt is one bit wider than vec, so it cannot overflow in one sweep
                if (mismatch) begin
                    err_cnt <= err_cnt + (VW+1)'(1);
                    if (!fail_valid) begin
                        fail_vec   <= vec;
                        fail_valid <= 1'b1;
                    end
                end
                if (!last_vec) vec <= vec + VW'(1);
            end
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_nand_quad_vec_checker.sv
// Scoreboard bench: stimulus queues the expected sweep result, monitors compare on done rising.
// u0 runs SETTLE=2 (768-cycle sweep), u1 runs SETTLE=1 (512-cycle sweep).
module tb_nand_quad_vec_checker;

    typedef struct {
        int        err;
        bit        fv;
        logic [7:0] fvec;
        int        acc;
        int        len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] a0, b0, y0, a1, b1, y1;
    logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [8:0] err0, err1;
    logic [7:0] fvec0, fvec1;
    int         mode0 = 0, mode1 = 0;
    int         cyc = 0;
    int         npass = 0, nchk = 0;
    exp_t       q0[$], q1[$];
    exp_t       e0, e1;
    logic       done0_q = 1'b0, done1_q = 1'b0;
    logic [7:0] ab1_q = 8'h00;
    bit         seen1 = 1'b0;
    int         hold1 = 0, hold_chk = 0, hold_bad = 0;
    int         base_chk, base_bad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] gate(int m, logic [3:0] a, logic [3:0] b);
        case (m)
            0:       return ~(a & b);
            1:       return ~(a & b) | 4'b0100;
            default: return a & b;
        endcase
    endfunction

    assign y0 = gate(mode0, a0, b0);
    assign y1 = gate(mode1, a1, b1);

    nand_quad_vec_checker #(.W(4), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
    );

    nand_quad_vec_checker #(.W(4), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor for u0
    always @(negedge clk) begin
        done0_q <= done0;
        if (done0 && !done0_q) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_done", 32'(done0), 32'(0));
            end else begin
                e0 = q0.pop_front();
                chk("u0_err_cnt", 32'(err0), 32'(e0.err));
                chk("u0_fail_valid", 32'(fv0), 32'(e0.fv));
                if (e0.fv) chk("u0_fail_vec", 32'(fvec0), 32'(e0.fvec));
                chk("u0_pass", 32'(pass0), 32'(e0.err == 0));
                chk("u0_latency", 32'(cyc - e0.acc), 32'(e0.len));
            end
        end
    end

    // monitor for u1
    always @(negedge clk) begin
        done1_q <= done1;
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_done", 32'(done1), 32'(0));
            end else begin
                e1 = q1.pop_front();
                chk("u1_err_cnt", 32'(err1), 32'(e1.err));
                chk("u1_fail_valid", 32'(fv1), 32'(e1.fv));
                if (e1.fv) chk("u1_fail_vec", 32'(fvec1), 32'(e1.fvec));
                chk("u1_pass", 32'(pass1), 32'(e1.err == 0));
                chk("u1_latency", 32'(cyc - e1.acc), 32'(e1.len));
            end
        end
    end

    // per-vector hold length on u1 drive while busy
    always @(negedge clk) begin
        ab1_q <= {b1, a1};
        if (busy1) begin
            if ({b1, a1} != ab1_q) begin
                if (seen1) begin
                    hold_chk <= hold_chk + 1;
                    if (hold1 != 2) hold_bad <= hold_bad + 1;
                end
                hold1 <= 1;
                seen1 <= 1'b1;
            end else begin
                hold1 <= hold1 + 1;
            end
        end else begin
            seen1 <= 1'b0;
        end
    end

    task automatic pulse0(bit push, int err, bit fv, logic [7:0] fvec);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.err = err; e.fv = fv; e.fvec = fvec; e.acc = cyc + 1; e.len = 768;
            q0.push_back(e);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic pulse1(int err, bit fv, logic [7:0] fvec);
        exp_t e;
        @(negedge clk);
        e.err = err; e.fv = fv; e.fvec = fvec; e.acc = cyc + 1; e.len = 512;
        q1.push_back(e);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done0) chk("u0_timeout", 32'(done0), 32'(1));
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!done1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk("u1_timeout", 32'(done1), 32'(1));
    endtask

    task automatic chk_zero0(string tag);
        chk({tag, "_a"}, 32'(a0), 32'(0));
        chk({tag, "_b"}, 32'(b0), 32'(0));
        chk({tag, "_busy"}, 32'(busy0), 32'(0));
        chk({tag, "_done"}, 32'(done0), 32'(0));
        chk({tag, "_pass"}, 32'(pass0), 32'(0));
        chk({tag, "_err"}, 32'(err0), 32'(0));
        chk({tag, "_fv"}, 32'(fv0), 32'(0));
        chk({tag, "_fvec"}, 32'(fvec0), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero0("reset");
        chk("reset_u1_done", 32'(done1), 32'(0));
        chk("reset_u1_err", 32'(err1), 32'(0));

        // 1: ideal gate
        mode0 = 0;
        pulse0(1, 0, 0, 8'h00);
        chk("busy_after_start", 32'(busy0), 32'(1));
        wait_done0();

        // 2: Y[2] stuck-at-1, restart from DONE
        mode0 = 1;
        pulse0(1, 64, 1, 8'h44);
        chk("restart_done_drops", 32'(done0), 32'(0));
        wait_done0();
        chk("hold_last_vec", 32'({b0, a0}), 32'(8'hff));

        // 3: AND instead of NAND
        mode0 = 2;
        pulse0(1, 256, 1, 8'h00);
        wait_done0();

        // 4: start re-pulsed mid-sweep is ignored
        mode0 = 0;
        pulse0(1, 0, 0, 8'h00);
        repeat (98) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("repulse_busy", 32'(busy0), 32'(1));
        wait_done0();

        // 5: rst at cycle 300 aborts, then a fresh full run
        mode0 = 1;
        pulse0(0, 0, 0, 8'h00);
        repeat (298) @(negedge clk);
        chk("pre_rst_err_nonzero", 32'(err0 != 0), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero0("midrst");
        repeat (5) @(negedge clk);
        chk("idle_stays_idle", 32'(busy0), 32'(0));
        mode0 = 0;
        pulse0(1, 0, 0, 8'h00);
        wait_done0();

        // 6: SETTLE=1, faulty run then restart from DONE with ideal gate
        mode1 = 2;
        pulse1(256, 1, 8'h00);
        wait_done1();
        mode1 = 0;
        base_chk = hold_chk;
        base_bad = hold_bad;
        pulse1(0, 0, 8'h00);
        chk("u1_restart_clears_err", 32'(err1), 32'(0));
        chk("u1_restart_done_drops", 32'(done1), 32'(0));
        wait_done1();
        repeat (2) @(negedge clk);
        chk("u1_hold_intervals", 32'(hold_chk - base_chk), 32'(255));
        chk("u1_hold_bad", 32'(hold_bad - base_bad), 32'(0));

        chk("q0_drained", 32'(q0.size()), 32'(0));
        chk("q1_drained", 32'(q1.size()), 32'(0));
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
